// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// instruction field positions, NOP and reset PC defaults.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {instr, pcplus4} plus a valid bit.
// A clear on the same edge as a load still takes the data but leaves it invalid.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_d,
    input  logic [31:0] pcplus4_d,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= NOP;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else begin
            if (load) begin
                instr   <= instr_d;
                pcplus4 <= pcplus4_d;
            end
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, a one-word skid buffer for decode
// stalls, and the FETCH/HOLD/DRAIN request FSM feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pcplus4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  drain_addr, drain_addr_d;
    logic [31:0]  skid, skid_d;
    logic         ld, clr;
    logic [31:0]  ld_instr, ld_pcplus4;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= word_align(RESET_PC);
            drain_addr <= 32'h0;
            skid       <= NOP;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            drain_addr <= drain_addr_d;
            skid       <= skid_d;
        end
    end

    // A redirect overrides everything; DRAIN is only needed when the old
    // request is still in flight, since its data must be swallowed.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        drain_addr_d = drain_addr;
        skid_d       = skid;
        ld           = 1'b0;
        clr          = flush;
        ld_instr     = imem_rdata;
        ld_pcplus4   = pc_plus4;

        case (state)
            FETCH: begin
                if (imem_valid) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        skid_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        ld = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    ld         = 1'b1;
                    ld_instr   = skid;
                    ld_pcplus4 = pc;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (imem_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (pcsrc) begin
            pc_d   = word_align(branch_target);
            ld     = 1'b0;
            clr    = 1'b1;
            skid_d = NOP;
            if (state == FETCH && !imem_valid) begin
                state_d      = DRAIN;
                drain_addr_d = pc;
            end else if (state == DRAIN && !imem_valid) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end
    end

    assign imem_req  = rst_n && (state != HOLD);
    assign imem_addr = word_align((state == DRAIN) ? drain_addr : pc);

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .clear     (clr),
        .instr_d   (ld_instr),
        .pcplus4_d (ld_pcplus4),
        .instr     (if_id_instr),
        .pcplus4   (if_id_pcplus4),
        .valid     (if_id_valid)
    );

    assign opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = if_id_instr[RS_MSB:RS_LSB];
    assign rt     = if_id_instr[RT_MSB:RT_LSB];
    assign rd     = if_id_instr[RD_MSB:RD_LSB];
    assign imm16  = if_id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table on a zero-wait memory, then
// hand-written redirect/drain and reset sequences on a 2-wait memory.
module tb_fetch_stage;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPcPlus4;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    logic [3:0]  memWait;
    logic [3:0]  memCnt;

    int testsRun;
    int testsFailed;

    vec_t tbl[$];
    vec_t expQ[$];

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .pcsrc         (pcsrc),
        .branch_target (branchTarget),
        .imem_req      (imemReq),
        .imem_addr     (imemAddr),
        .imem_rdata    (imemRdata),
        .imem_valid    (imemValid),
        .if_id_instr   (ifIdInstr),
        .if_id_pcplus4 (ifIdPcPlus4),
        .if_id_valid   (ifIdValid),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .imm16         (imm16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: returns the address as data (one special word at 0x200),
    // answering memWait cycles after the request rises.
    assign imemRdata = (imemAddr == 32'h0000_0200) ? 32'h2008_FFFF : imemAddr;
    assign imemValid = imemReq && (memCnt == memWait);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) memCnt <= 4'd0;
        else if (!imemReq || imemValid) memCnt <= 4'd0;
        else memCnt <= memCnt + 4'd1;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic p, input logic [31:0] t,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] instr, input logic [31:0] p4);
        vec_t r;
        r.stall = s; r.flush = f; r.pcsrc = p; r.target = t;
        r.expReq = req; r.expAddr = addr; r.expValid = v;
        r.expInstr = instr; r.expPcPlus4 = p4;
        return r;
    endfunction

    task automatic checkOutput(input string tag);
        vec_t e;
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = expQ.pop_front();
            cmp({tag, " req"}, {31'd0, imemReq}, {31'd0, e.expReq});
            if (e.expReq) cmp({tag, " addr"}, imemAddr, e.expAddr);
            cmp({tag, " valid"}, {31'd0, ifIdValid}, {31'd0, e.expValid});
            cmp({tag, " instr"}, ifIdInstr, e.expInstr);
            cmp({tag, " pcplus4"}, ifIdPcPlus4, e.expPcPlus4);
            cmp({tag, " opcode"}, {26'd0, opcode}, {26'd0, e.expInstr[31:26]});
            cmp({tag, " rt"}, {27'd0, rt}, {27'd0, e.expInstr[20:16]});
            cmp({tag, " imm16"}, {16'd0, imm16}, {16'd0, e.expInstr[15:0]});
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        stall = v.stall;
        flush = v.flush;
        pcsrc = v.pcsrc;
        branchTarget = v.target;
        expQ.push_back(v);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, " req"}, {31'd0, imemReq}, 32'd0);
        cmp({tag, " valid"}, {31'd0, ifIdValid}, 32'd0);
        cmp({tag, " instr"}, ifIdInstr, 32'd0);
        cmp({tag, " pcplus4"}, ifIdPcPlus4, 32'd0);
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        pcsrc = 1'b0;
        branchTarget = 32'h0;
        memWait = 4'd0;

        // Zero-wait table: inputs for the cycle, outputs seen in that cycle.
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h0,       0,32'h0,       32'h0));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h4,       1,32'h0,       32'h4));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h8,       1,32'h4,       32'h8));
        tbl.push_back(mk(1,0,0,32'h0,        1,32'hC,       1,32'h8,       32'hC));
        tbl.push_back(mk(1,0,0,32'h0,        0,32'h10,      1,32'h8,       32'hC));
        tbl.push_back(mk(1,0,0,32'h0,        0,32'h10,      1,32'h8,       32'hC));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h10,      1,32'h8,       32'hC));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h10,      1,32'hC,       32'h10));
        tbl.push_back(mk(0,1,0,32'h0,        1,32'h14,      1,32'h10,      32'h14));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h18,      0,32'h14,      32'h18));
        tbl.push_back(mk(0,0,1,32'h200,      1,32'h1C,      1,32'h18,      32'h1C));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h200,     0,32'h18,      32'h1C));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF, 1,32'h204,     1,32'h2008FFFF,32'h204));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'hFFFFFFFC,0,32'h2008FFFF,32'h204));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h0,       1,32'hFFFFFFFC,32'h0));
        tbl.push_back(mk(1,0,0,32'h0,        1,32'h4,       1,32'h0,       32'h4));
        tbl.push_back(mk(1,0,1,32'h300,      0,32'h8,       1,32'h0,       32'h4));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h300,     0,32'h0,       32'h4));
        tbl.push_back(mk(1,1,0,32'h0,        1,32'h304,     1,32'h300,     32'h304));
        tbl.push_back(mk(1,0,0,32'h0,        0,32'h308,     0,32'h300,     32'h304));
        tbl.push_back(mk(0,0,0,32'h0,        0,32'h308,     0,32'h300,     32'h304));
        tbl.push_back(mk(0,0,0,32'h0,        1,32'h308,     1,32'h304,     32'h308));

        #2;
        checkReset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
            if (i == 12) begin
                cmp("field rs", {27'd0, rs}, 32'd0);
                cmp("field rt", {27'd0, rt}, 32'd8);
                cmp("field opcode", {26'd0, opcode}, 32'h8);
                cmp("field imm16", {16'd0, imm16}, 32'hFFFF);
                cmp("field rd", {27'd0, rd}, 32'h1F);
            end
        end

        // Restart with a 2-wait memory for the redirect-while-outstanding cases.
        rst_n = 1'b0;
        memWait = 4'd2;
        stall = 1'b0; flush = 1'b0; pcsrc = 1'b0;
        #1;
        checkReset("reset2");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(mk(0,0,1,32'h40, 1,32'h0,  0,32'h0,  32'h0),   "drain0");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h0,  0,32'h0,  32'h0),   "drain1");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h0,  0,32'h0,  32'h0),   "drain2");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h40, 0,32'h0,  32'h0),   "drain3");
        applyStimulus(mk(0,0,1,32'h100,1,32'h40, 0,32'h0,  32'h0),   "drain4");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h40, 0,32'h0,  32'h0),   "drain5");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h100,0,32'h0,  32'h0),   "drain6");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h100,0,32'h0,  32'h0),   "drain7");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h100,0,32'h0,  32'h0),   "drain8");
        applyStimulus(mk(0,0,1,32'h500,1,32'h104,1,32'h100,32'h104), "drain9");
        applyStimulus(mk(0,0,1,32'h600,1,32'h104,0,32'h100,32'h104), "drain10");
        applyStimulus(mk(0,0,0,32'h0,  1,32'h104,0,32'h100,32'h104), "drain11");
        applyStimulus(mk(0,0,1,32'h700,1,32'h600,0,32'h100,32'h104), "drain12");

        // Reset asserted while DRAIN still waits on the stale word.
        stall = 1'b0; flush = 1'b0; pcsrc = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(mk(0,0,0,32'h0, 1,32'h0, 0,32'h0, 32'h0), "restart0");
        applyStimulus(mk(0,0,0,32'h0, 1,32'h0, 0,32'h0, 32'h0), "restart1");
        applyStimulus(mk(0,0,0,32'h0, 1,32'h0, 0,32'h0, 32'h0), "restart2");
        applyStimulus(mk(0,0,0,32'h0, 1,32'h4, 1,32'h0, 32'h4), "restart3");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
